ram256: RTL and testbench



---
 rtl/ram256_pkg.sv | 18 +
 rtl/ram_word.sv | 37 +++
 rtl/ram256.sv | 95 +++++++++
 tb/tb_ram256.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ram256_pkg.sv
// Shared sizing constants and helpers for the 256-word RAM macro.
package ram256_pkg;

    localparam int RAM_DEPTH  = 256;
    localparam int ADDR_W     = 8;
    localparam int BYTE_W     = 8;
    localparam int BANKS      = 4;
    localparam int BANK_DEPTH = RAM_DEPTH / BANKS;
    localparam int BANK_AW    = $clog2(BANK_DEPTH);
    localparam int BANK_SW    = ADDR_W - BANK_AW;

    typedef logic [ADDR_W-1:0] addr_t;

    function automatic logic [BANK_DEPTH-1:0] wordDecode(input logic [BANK_AW-1:0] idx);
        return BANK_DEPTH'(1) << idx;
    endfunction

endpackage

// File: rtl/ram_word.sv
// One storage word made of WSIZE byte cells, built either from latches or flip-flops.
// A byte cell loads only when the word is selected, the port is enabled and its lane strobe is set.
module ram_word
    import ram256_pkg::*;
#(
    parameter int USE_LATCH = 1,
    parameter int WSIZE     = 2
) (
    input  logic                    i_clk,
    input  logic                    i_sel,
    input  logic                    i_en,
    input  logic [WSIZE-1:0]        i_we,
    input  logic [WSIZE*BYTE_W-1:0] i_di,
    output logic [WSIZE*BYTE_W-1:0] o_do
);

    for (genvar b = 0; b < WSIZE; b++) begin : g_byte
        logic              w_gate;
        logic [BYTE_W-1:0] r_byte;

        assign w_gate = i_sel & i_en & i_we[b];

        if (USE_LATCH != 0) begin : g_latch
            // Open only while the clock is low, after the output register has sampled.
            always_latch begin
                if (w_gate && !i_clk) r_byte = i_di[b*BYTE_W +: BYTE_W];
            end
        end else begin : g_dff
            always_ff @(posedge i_clk) begin
                if (w_gate) r_byte <= i_di[b*BYTE_W +: BYTE_W];
            end
        end

        assign o_do[b*BYTE_W +: BYTE_W] = r_byte;
    end

endmodule

// File: rtl/ram256.sv
// 256-word single-port RAM, 4 banks of 64 words, per-byte write enables, read-first
// behaviour and a registered read port that is cleared by the asynchronous reset.
module ram256
    import ram256_pkg::*;
#(
    parameter int USE_LATCH = 1,
    parameter int WSIZE     = 2
) (
`ifdef USE_POWER_PINS
    inout  wire                     VPWR,
    inout  wire                     VGND,
`endif
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN0,
    input  logic [WSIZE-1:0]        WE0,
    input  addr_t                   A0,
    input  logic [WSIZE*BYTE_W-1:0] Di0,
    output logic [WSIZE*BYTE_W-1:0] Do0
);

    localparam int DW = WSIZE * BYTE_W;

    addr_t            w_wrAddr;
    logic             w_wrEn;
    logic [WSIZE-1:0] w_wrWe;
    logic [DW-1:0]    w_wrData;
    logic [DW-1:0]    w_bankData [BANKS];
    logic [DW-1:0]    w_rdData;
    logic [DW-1:0]    r_do;

    if (USE_LATCH != 0) begin : g_stage
        addr_t            r_wrAddr;
        logic             r_wrEn;
        logic [WSIZE-1:0] r_wrWe;
        logic [DW-1:0]    r_wrData;

        // The request is frozen at the rising edge and written during the following
        // low phase, so the read mux never sees a cell change while Do0 samples it.
        always_ff @(posedge CLK) begin
            r_wrAddr <= A0;
            r_wrEn   <= EN0;
            r_wrWe   <= WE0;
            r_wrData <= Di0;
        end

        assign w_wrAddr = r_wrAddr;
        assign w_wrEn   = r_wrEn;
        assign w_wrWe   = r_wrWe;
        assign w_wrData = r_wrData;
    end else begin : g_direct
        assign w_wrAddr = A0;
        assign w_wrEn   = EN0;
        assign w_wrWe   = WE0;
        assign w_wrData = Di0;
    end

    for (genvar bk = 0; bk < BANKS; bk++) begin : g_bank
        logic                  w_bankSel;
        logic [BANK_DEPTH-1:0] w_wordSel;
        logic [DW-1:0]         w_bankWords [BANK_DEPTH];

        assign w_bankSel = (w_wrAddr[ADDR_W-1:BANK_AW] == BANK_SW'(bk));
        assign w_wordSel = wordDecode(w_wrAddr[BANK_AW-1:0]);

        for (genvar wd = 0; wd < BANK_DEPTH; wd++) begin : g_word
            ram_word #(
                .USE_LATCH (USE_LATCH),
                .WSIZE     (WSIZE)
            ) u_word (
                .i_clk (CLK),
                .i_sel (w_bankSel & w_wordSel[wd]),
                .i_en  (w_wrEn),
                .i_we  (w_wrWe),
                .i_di  (w_wrData),
                .o_do  (w_bankWords[wd])
            );
        end

        assign w_bankData[bk] = w_bankWords[A0[BANK_AW-1:0]];
    end

    assign w_rdData = w_bankData[A0[ADDR_W-1:BANK_AW]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_do <= '0;
        end else if (EN0) begin
            r_do <= w_rdData;
        end
    end

    assign Do0 = r_do;

endmodule

// File: tb/tb_ram256.sv
// Scoreboard bench driving four ram256 builds (latch/flop x 16/32-bit) with one stimulus stream.
module tb_ram256;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0;
    logic [3:0]  we0;
    logic [7:0]  a0;
    logic [31:0] di0;
    logic [15:0] doL2;
    logic [15:0] doF2;
    logic [31:0] doL4;
    logic [31:0] doF4;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          valid;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    logic [31:0] model [256];
    logic [3:0]  known [256];
    logic [31:0] expDo;
    bit          expValid;

    always #5 clk = ~clk;

    ram256 #(.USE_LATCH(1), .WSIZE(2)) dutL2 (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0[1:0]), .A0(a0), .Di0(di0[15:0]), .Do0(doL2)
    );
    ram256 #(.USE_LATCH(0), .WSIZE(2)) dutF2 (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0[1:0]), .A0(a0), .Di0(di0[15:0]), .Do0(doF2)
    );
    ram256 #(.USE_LATCH(1), .WSIZE(4)) dutL4 (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(doL4)
    );
    ram256 #(.USE_LATCH(0), .WSIZE(4)) dutF4 (
        .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(doF4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] expected);
        checkOutput({tag, "/latch16"}, {16'h0, doL2}, {16'h0, expected[15:0]});
        checkOutput({tag, "/flop16"},  {16'h0, doF2}, {16'h0, expected[15:0]});
        checkOutput({tag, "/latch32"}, doL4, expected);
        checkOutput({tag, "/flop32"},  doF4, expected);
    endtask

    // Upper 16 bits of the 32-bit builds get a scrambled copy so both halves are exercised.
    task automatic applyStimulus(input bit en, input logic [1:0] we2, input logic [7:0] addr,
                                 input logic [15:0] d, input string tag);
        sbEntry_t e;
        @(negedge clk);
        en0 = en;
        we0 = {we2, we2};
        a0  = addr;
        di0 = {d ^ 16'h5AA5, d};
        if (rst) begin
            expDo    = '0;
            expValid = 1'b1;
        end else if (en) begin
            expDo    = model[addr];
            expValid = &known[addr];
        end
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we0[b]) begin
                    model[addr][b*8 +: 8] = di0[b*8 +: 8];
                    known[addr][b] = 1'b1;
                end
            end
        end
        e.tag   = tag;
        e.exp   = expDo;
        e.valid = expValid;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        if (e.valid) checkAll(e.tag, e.exp);
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b0;
        we0 = 4'h0;
        a0  = 8'h00;
        di0 = 32'h0;
        expDo    = '0;
        expValid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            known[i] = 4'h0;
            model[i] = '0;
        end
        repeat (2) @(negedge clk);
        checkAll("reset", 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 2'b11, 8'(i), 16'(i), $sformatf("fillW%0d", i));
            applyStimulus(1'b1, 2'b00, 8'(i), 16'h0, $sformatf("fillR%0d", i));
        end

        applyStimulus(1'b1, 2'b11, 8'd7, 16'hA5A5, "laneW0");
        applyStimulus(1'b1, 2'b01, 8'd7, 16'h3C3C, "laneW1");
        applyStimulus(1'b1, 2'b00, 8'd7, 16'h0000, "laneR1");
        applyStimulus(1'b1, 2'b10, 8'd7, 16'hFF00, "laneW2");
        applyStimulus(1'b1, 2'b00, 8'd7, 16'h0000, "laneR2");

        applyStimulus(1'b1, 2'b11, 8'd3, 16'h1111, "rfW0");
        applyStimulus(1'b1, 2'b11, 8'd3, 16'h2222, "rfSameEdge");
        applyStimulus(1'b1, 2'b00, 8'd3, 16'h0000, "rfReadNew");

        applyStimulus(1'b1, 2'b11, 8'd9, 16'h5555, "enW");
        applyStimulus(1'b1, 2'b00, 8'd9, 16'h0000, "enR");
        applyStimulus(1'b0, 2'b11, 8'd9, 16'h0000, "enOffHold");
        applyStimulus(1'b0, 2'b11, 8'd200, 16'h1234, "enOffHold2");
        applyStimulus(1'b1, 2'b00, 8'd9, 16'h0000, "enKept");
        applyStimulus(1'b1, 2'b00, 8'd200, 16'h0000, "enKept2");

        applyStimulus(1'b1, 2'b11, 8'd20, 16'hBEEF, "rstW");
        applyStimulus(1'b1, 2'b00, 8'd20, 16'h0000, "rstPre");
        #3;
        rst = 1'b1;
        #1;
        checkAll("rstAsync", 32'h0);
        applyStimulus(1'b1, 2'b11, 8'd21, 16'hC0DE, "rstHeldW");
        applyStimulus(1'b1, 2'b00, 8'd20, 16'h0000, "rstHeldR");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 2'b00, 8'd20, 16'h0000, "rstAfter20");
        applyStimulus(1'b1, 2'b00, 8'd21, 16'h0000, "rstAfter21");
        applyStimulus(1'b1, 2'b00, 8'd255, 16'h0000, "topAddr");
        applyStimulus(1'b1, 2'b00, 8'd0, 16'h0000, "bottomAddr");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
